// File: rtl/led_cube_playlist_scheduler_if.sv
// Control/status bundle of the LED cube playlist scheduler.
// slave = scheduler side, master = host/driver side.
interface led_cube_playlist_scheduler_if;
    logic       play;
    logic       stop;
    logic       pause;
    logic       pl_wr_en;
    logic [2:0] pl_wr_addr;
    logic [2:0] pl_wr_anim;
    logic [2:0] pl_wr_loops;
    logic [2:0] pl_last;
    logic       frame_done;
    logic       frame_start;
    logic [2:0] anim_id;
    logic [7:0] frame_offset;
    logic [2:0] entry_idx;
    logic       busy;
    logic       pl_wrap;

    modport master (
        output play, stop, pause, pl_wr_en, pl_wr_addr, pl_wr_anim, pl_wr_loops, pl_last, frame_done,
        input  frame_start, anim_id, frame_offset, entry_idx, busy, pl_wrap
    );

    modport slave (
        input  play, stop, pause, pl_wr_en, pl_wr_addr, pl_wr_anim, pl_wr_loops, pl_last, frame_done,
        output frame_start, anim_id, frame_offset, entry_idx, busy, pl_wrap
    );
endinterface

// File: rtl/led_cube_playlist_scheduler.sv
// Walks a programmable (animation, loop-count) playlist frame by frame with a frame-done handshake.
// Optional pause support is compiled in with `define LED_CUBE_PAUSE_EN.
module led_cube_playlist_scheduler #(
    parameter int unsigned NUM_ANIM   = 7,
    parameter int unsigned FRAMES     = 150,
    parameter int unsigned FRAME_TIME = 21'h16E360,
    parameter int unsigned PL_DEPTH   = 8
) (
    input  logic                         clk,
    input  logic                         rst_n,
    led_cube_playlist_scheduler_if.slave sched
);
    localparam int unsigned   TW         = (FRAME_TIME > 1) ? $clog2(FRAME_TIME) : 1;
    localparam logic [TW-1:0] TIMER_LAST = TW'(FRAME_TIME - 1);
    localparam logic [7:0]    LAST_FRAME = 8'(FRAMES - 1);

    typedef enum logic [1:0] {IDLE, START, RUN, ADVANCE} state_e;

    state_e        state_q, state_d;
    logic [2:0]    pl_anim  [PL_DEPTH];
    logic [2:0]    pl_loops [PL_DEPTH];
    logic [TW-1:0] timer_q;
    logic          done_seen_q;
    logic [2:0]    anim_q;
    logic [2:0]    entry_q;
    logic [2:0]    loop_cnt_q;
    logic [2:0]    loops_cur_q;
    logic [7:0]    offset_q;
    logic          wrap_q;
    logic          hold;
    logic          advance_ok;
    logic          last_entry;
    logic [2:0]    next_entry;

`ifdef LED_CUBE_PAUSE_EN
    assign hold = sched.pause;
`else
    assign hold = 1'b0;
`endif

    // An index already past a shrunken pl_last also wraps to entry 0.
    assign last_entry = (entry_q >= sched.pl_last);
    assign next_entry = last_entry ? 3'd0 : entry_q + 3'd1;
    assign advance_ok = (timer_q == TIMER_LAST) && (done_seen_q || sched.frame_done) && !hold;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state_q <= IDLE;
        else        state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (sched.play) state_d = START;
            START:   state_d = RUN;
            RUN:     if (advance_ok) state_d = ADVANCE;
            ADVANCE: state_d = START;
            default: state_d = IDLE;
        endcase
        if (sched.stop) state_d = IDLE;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int unsigned i = 0; i < PL_DEPTH; i++) begin
                pl_anim[i]  <= '0;
                pl_loops[i] <= '0;
            end
        end else if (sched.pl_wr_en) begin
            pl_anim[sched.pl_wr_addr]  <= sched.pl_wr_anim;
            pl_loops[sched.pl_wr_addr] <= sched.pl_wr_loops;
        end
    end

    // Entry loads read the playlist before a same-edge write lands, so they see the old entry.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            timer_q     <= '0;
            done_seen_q <= 1'b0;
            anim_q      <= '0;
            entry_q     <= '0;
            loop_cnt_q  <= '0;
            loops_cur_q <= '0;
            offset_q    <= '0;
            wrap_q      <= 1'b0;
        end else begin
            wrap_q <= 1'b0;
            if (sched.stop) begin
                anim_q      <= '0;
                entry_q     <= '0;
                loop_cnt_q  <= '0;
                loops_cur_q <= '0;
                offset_q    <= '0;
            end else begin
                case (state_q)
                    IDLE: begin
                        if (sched.play) begin
                            anim_q      <= pl_anim[3'd0];
                            loops_cur_q <= pl_loops[3'd0];
                            entry_q     <= '0;
                            loop_cnt_q  <= '0;
                            offset_q    <= '0;
                        end
                    end
                    START: begin
                        timer_q     <= '0;
                        done_seen_q <= 1'b0;
                    end
                    RUN: begin
                        if (!hold && (timer_q != TIMER_LAST)) timer_q <= timer_q + 1'b1;
                        if (sched.frame_done) done_seen_q <= 1'b1;
                    end
                    ADVANCE: begin
                        if (offset_q < LAST_FRAME) begin
                            offset_q <= offset_q + 8'd1;
                        end else begin
                            offset_q <= '0;
                            if (loop_cnt_q < loops_cur_q) begin
                                loop_cnt_q <= loop_cnt_q + 3'd1;
                            end else begin
                                loop_cnt_q  <= '0;
                                entry_q     <= next_entry;
                                anim_q      <= pl_anim[next_entry];
                                loops_cur_q <= pl_loops[next_entry];
                                wrap_q      <= last_entry;
                            end
                        end
                    end
                    default: ;
                endcase
            end
        end
    end

    assign sched.frame_start  = (state_q == START);
    assign sched.busy         = (state_q != IDLE);
    assign sched.anim_id      = anim_q;
    assign sched.frame_offset = offset_q;
    assign sched.entry_idx    = entry_q;
    assign sched.pl_wrap      = wrap_q;
endmodule

// File: tb/tb_led_cube_playlist_scheduler.sv
// Directed bench for led_cube_playlist_scheduler: a frame-level schedule model checked every
// cycle, plus literal expectations for walk order, frame periods, stop, live write and reset.
module tb_led_cube_playlist_scheduler;
    localparam int FT = 16;
    localparam int NF = 4;

    logic clk = 1'b0;
    logic rst_n;
    always #5 clk = ~clk;

    led_cube_playlist_scheduler_if sched ();

    led_cube_playlist_scheduler #(
        .NUM_ANIM  (7),
        .FRAMES    (NF),
        .FRAME_TIME(FT),
        .PL_DEPTH  (8)
    ) dut (
        .clk  (clk),
        .rst_n(rst_n),
        .sched(sched)
    );

    int n_cmp = 0;
    int n_bad = 0;
    int cyc = 0;
    int driver_delay = 10;
    int pause_plan = 0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input int act, input int exp);
        n_cmp++;
        if (act != exp) begin
            n_bad++;
            $display("FAIL %s: got %0d, want %0d (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Driver model: one frame_done pulse driver_delay cycles after each frame_start.
    initial begin
        int d;
        sched.frame_done = 1'b0;
        forever begin
            @(negedge clk);
            if (sched.frame_start) begin
                d = driver_delay;
                repeat (d) @(posedge clk);
                #1 sched.frame_done = 1'b1;
                @(posedge clk);
                #1 sched.frame_done = 1'b0;
            end
        end
    end

    // Frame length: the run phase lasts FRAME_TIME plus paused cycles, or until the driver reports.
    function automatic int frame_period();
        int run_len;
        run_len = FT;
`ifdef LED_CUBE_PAUSE_EN
        run_len += pause_plan;
`endif
        return ((driver_delay > run_len) ? driver_delay : run_len) + 2;
    endfunction

    int m_anim [8];
    int m_loops [8];
    int m_busy, m_a, m_off, m_ent, m_loop, m_cur_loops, m_fs, m_wrap, next_start;
    int p_play, p_stop, p_wr, p_addr, p_wanim, p_wloops, p_last;

    initial begin
        forever begin
            @(negedge clk);
            if (!rst_n) begin
                for (int i = 0; i < 8; i++) begin
                    m_anim[i]  = 0;
                    m_loops[i] = 0;
                end
                m_busy = 0; m_a = 0; m_off = 0; m_ent = 0; m_loop = 0; m_cur_loops = 0;
                m_fs = 0; m_wrap = 0; next_start = 0;
            end else begin
                m_fs = 0;
                m_wrap = 0;
                if (p_stop != 0) begin
                    m_busy = 0; m_a = 0; m_off = 0; m_ent = 0; m_loop = 0;
                end else if (m_busy == 0 && p_play != 0) begin
                    m_busy = 1; m_ent = 0; m_off = 0; m_loop = 0;
                    m_a = m_anim[0];
                    m_cur_loops = m_loops[0];
                    m_fs = 1;
                    next_start = cyc + frame_period();
                end else if (m_busy != 0 && cyc == next_start) begin
                    m_fs = 1;
                    next_start = cyc + frame_period();
                    if (m_off < NF - 1) begin
                        m_off++;
                    end else begin
                        m_off = 0;
                        if (m_loop < m_cur_loops) begin
                            m_loop++;
                        end else begin
                            m_loop = 0;
                            if (m_ent >= p_last) begin
                                m_ent = 0;
                                m_wrap = 1;
                            end else begin
                                m_ent++;
                            end
                            m_a = m_anim[m_ent];
                            m_cur_loops = m_loops[m_ent];
                        end
                    end
                end
                if (p_wr != 0) begin
                    m_anim[p_addr]  = p_wanim;
                    m_loops[p_addr] = p_wloops;
                end
            end
            chk("frame_start", int'(sched.frame_start), m_fs);
            chk("busy", int'(sched.busy), m_busy);
            chk("anim_id", int'(sched.anim_id), m_a);
            chk("frame_offset", int'(sched.frame_offset), m_off);
            chk("entry_idx", int'(sched.entry_idx), m_ent);
            chk("pl_wrap", int'(sched.pl_wrap), m_wrap);
            p_play   = rst_n ? int'(sched.play) : 0;
            p_stop   = rst_n ? int'(sched.stop) : 0;
            p_wr     = rst_n ? int'(sched.pl_wr_en) : 0;
            p_addr   = int'(sched.pl_wr_addr);
            p_wanim  = int'(sched.pl_wr_anim);
            p_wloops = int'(sched.pl_wr_loops);
            p_last   = int'(sched.pl_last);
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic pl_write(input int addr, input int anim, input int loops);
        tick();
        sched.pl_wr_en    = 1'b1;
        sched.pl_wr_addr  = 3'(addr);
        sched.pl_wr_anim  = 3'(anim);
        sched.pl_wr_loops = 3'(loops);
        tick();
        sched.pl_wr_en = 1'b0;
    endtask

    task automatic pulse_play();
        tick();
        sched.play = 1'b1;
        tick();
        sched.play = 1'b0;
    endtask

    task automatic wait_fs(input string tag, output int t, output int a, output int off,
                           output int ent, output int w);
        int n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (!sched.frame_start && n < 300);
        if (!sched.frame_start) chk({tag, "_fs_timeout"}, int'(sched.frame_start), 1);
        t   = cyc;
        a   = int'(sched.anim_id);
        off = int'(sched.frame_offset);
        ent = int'(sched.entry_idx);
        w   = int'(sched.pl_wrap);
    endtask

    int walk_anim [13] = '{2, 2, 2, 2, 5, 5, 5, 5, 5, 5, 5, 5, 2};
    int walk_off  [13] = '{0, 1, 2, 3, 0, 1, 2, 3, 0, 1, 2, 3, 0};
    int walk_ent  [13] = '{0, 0, 0, 0, 1, 1, 1, 1, 1, 1, 1, 1, 0};
    int ft [13];
    int fa [13];
    int fo [13];
    int fe [13];
    int fw [13];
    int t0, t1, a, off, ent, w, wraps;

    initial begin
        rst_n = 1'b1;
        sched.play = 1'b0;
        sched.stop = 1'b0;
        sched.pause = 1'b0;
        sched.pl_wr_en = 1'b0;
        sched.pl_wr_addr = '0;
        sched.pl_wr_anim = '0;
        sched.pl_wr_loops = '0;
        sched.pl_last = '0;
        #1 rst_n = 1'b0;
        repeat (3) @(posedge clk);
        #1 rst_n = 1'b1;
        tick();
        chk("reset_busy", int'(sched.busy), 0);
        chk("reset_anim", int'(sched.anim_id), 0);
        chk("reset_offset", int'(sched.frame_offset), 0);

        // Basic walk: {2,0} then {5,1}, pl_last=1.
        pl_write(0, 2, 0);
        pl_write(1, 5, 1);
        tick();
        sched.pl_last = 3'd1;
        pulse_play();
        for (int i = 0; i < 13; i++) wait_fs("walk", ft[i], fa[i], fo[i], fe[i], fw[i]);
        wraps = 0;
        for (int i = 0; i < 13; i++) begin
            chk("walk_anim", fa[i], walk_anim[i]);
            chk("walk_offset", fo[i], walk_off[i]);
            chk("walk_entry", fe[i], walk_ent[i]);
            if (i > 0) chk("walk_period", ft[i] - ft[i-1], 18);
            wraps += fw[i];
        end
        chk("walk_wrap_at_12", fw[12], 1);
        chk("walk_wrap_count", wraps, 1);

        // Slow driver stretches the frame.
        tick();
        driver_delay = 30;
        wait_fs("slow", t0, a, off, ent, w);
        wait_fs("slow", t1, a, off, ent, w);
        chk("slow_period", t1 - t0, 32);
        tick();
        driver_delay = 10;

        // Stop at frame offset 3.
        for (int i = 0; i < 8; i++) begin
            wait_fs("stop_seek", t0, a, off, ent, w);
            if (off == 3) break;
        end
        chk("stop_seek_offset", off, 3);
        tick();
        sched.stop = 1'b1;
        tick();
        sched.stop = 1'b0;
        chk("stop_busy", int'(sched.busy), 0);
        chk("stop_anim", int'(sched.anim_id), 0);
        chk("stop_offset", int'(sched.frame_offset), 0);
        chk("stop_entry", int'(sched.entry_idx), 0);
        repeat (40) tick();

        // Stop and play together in IDLE.
        tick();
        sched.stop = 1'b1;
        sched.play = 1'b1;
        tick();
        sched.stop = 1'b0;
        sched.play = 1'b0;
        repeat (3) tick();
        chk("stop_play_busy", int'(sched.busy), 0);

        // Live write of entry 0, and pl_last shrunk below entry_idx.
        pulse_play();
        wait_fs("live", ft[0], fa[0], fo[0], fe[0], fw[0]);
        pl_write(0, 4, 0);
        for (int i = 1; i < 13; i++) begin
            wait_fs("live", ft[i], fa[i], fo[i], fe[i], fw[i]);
            if (i == 5) begin
                tick();
                sched.pl_last = 3'd0;
            end
        end
        chk("live_anim_f0", fa[0], 2);
        chk("live_anim_f3", fa[3], 2);
        chk("live_anim_f4", fa[4], 5);
        chk("live_anim_f12", fa[12], 4);
        chk("live_entry_f12", fe[12], 0);
        chk("live_wrap_f12", fw[12], 1);

        // Pause for 20 cycles in RUN.
        tick();
        pause_plan = 20;
        wait_fs("pause", t0, a, off, ent, w);
        fork
            begin
                tick();
                sched.pause = 1'b1;
                repeat (20) tick();
                sched.pause = 1'b0;
                pause_plan = 0;
            end
            wait_fs("pause", t1, a, off, ent, w);
        join
`ifdef LED_CUBE_PAUSE_EN
        chk("pause_period", t1 - t0, 38);
`else
        chk("pause_period", t1 - t0, 18);
`endif

        // Asynchronous reset at timer=7.
        wait_fs("rst", t0, a, off, ent, w);
        chk("rst_pre_anim", a, 4);
        repeat (8) @(posedge clk);
        #2 rst_n = 1'b0;
        #1;
        chk("rst_async_busy", int'(sched.busy), 0);
        chk("rst_async_anim", int'(sched.anim_id), 0);
        chk("rst_async_offset", int'(sched.frame_offset), 0);
        chk("rst_async_entry", int'(sched.entry_idx), 0);
        chk("rst_async_fs", int'(sched.frame_start), 0);
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;
        repeat (5) tick();
        pulse_play();
        wait_fs("post_rst", t0, a, off, ent, w);
        chk("post_rst_anim", a, 0);
        chk("post_rst_entry", ent, 0);

        tick();
        sched.stop = 1'b1;
        tick();
        sched.stop = 1'b0;
        repeat (5) tick();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule

// File: doc/led_cube_playlist_scheduler.md
# led_cube_playlist_scheduler

Sequences the LED cube's stored animations. Holds a small programmable playlist of (animation, loop-count) entries and walks it frame by frame. Generates the `frame_start` pulse for the single-frame driver and the `anim_id`/`frame_offset` pair that addresses the animation ROMs. It replaces the fixed loop/offset counters in the multi-frame wrapper with a programmable schedule, and adds a hard frame-done handshake with the driver.

## Interface
- `NUM_ANIM`, 7: number of stored animations; IDs 0..NUM_ANIM-1.
- `FRAMES`, 150: frames per animation; offset range 0..FRAMES-1.
- `FRAME_TIME`, 21'h16E360: minimum cycles per frame, counted from `frame_start`.
- `PL_DEPTH`, 8: playlist entries; index width is 3.

Ports:
- `clk` in 1: system clock.
- `rst_n` in 1: reset, asynchronous, active-low.
- `play` in 1: start pulse; honoured only in IDLE.
- `stop` in 1: abort pulse; honoured in any state.
- `pause` in 1: level; freezes sequencing (see Configuration).
- `pl_wr_en` in 1: playlist write strobe.
- `pl_wr_addr` in 3: playlist entry to write.
- `pl_wr_anim` in 3: animation ID for the written entry.
- `pl_wr_loops` in 3: repeat count for the written entry; the entry plays loops+1 times.
- `pl_last` in 3: index of the last valid entry.
- `frame_done` in 1: driver has finished one full frame scan.
- `frame_start` out 1: one-cycle pulse that starts the driver.
- `anim_id` out 3: current animation ID.
- `frame_offset` out 8: current frame number within the animation.
- `entry_idx` out 3: current playlist index.
- `busy` out 1: high whenever the state is not IDLE.
- `pl_wrap` out 1: one-cycle pulse when the schedule returns from entry `pl_last` to entry 0.

## Operation
The state machine has four states: IDLE, START, RUN and ADVANCE.
- **IDLE:** `play`=1 → START. Entering START loads entry 0. `anim_id` is taken from entry 0, and `frame_offset`, the loop counter and `entry_idx` are set to 0.
- **START:** `frame_start`=1 for exactly this one cycle. The frame timer is cleared to 0 and `done_seen` is cleared. Next state is RUN.
- **RUN:** the timer increments every cycle and saturates at FRAME_TIME-1. `done_seen` is set when `frame_done`=1. The block goes to ADVANCE when the timer equals FRAME_TIME-1 and either `done_seen`=1 or `frame_done`=1 in that same cycle. If the timer expires before the driver reports done, the block holds in RUN until `frame_done` arrives.
- **ADVANCE:** always goes to START on the next cycle.
  - If `frame_offset` < FRAMES-1, `frame_offset` increments by 1.
  - Otherwise `frame_offset` returns to 0. Then, if the loop counter is less than the entry's loops field, the loop counter increments by 1.
  - Otherwise the loop counter returns to 0 and the next entry is loaded. The next entry is `entry_idx`+1, or 0 when `entry_idx`==`pl_last`; the return to 0 also pulses `pl_wrap`.
- **Loading an entry** latches the entry's `anim_id` and loops field at the moment of loading. A write to the current entry therefore takes effect only the next time that entry is loaded.
- **Playlist writes** are accepted in any state and land on the clock edge. A simultaneous write to, and load of, the same entry loads the old value.
- **Out-of-range IDs:** an `anim_id` ≥ NUM_ANIM is passed through unchanged; the downstream mux blanks it.
- **Stop:** `stop` in any state → IDLE on the next edge. `frame_offset`, `entry_idx` and the loop counter are cleared. If `stop` and `play` are asserted in the same cycle, `stop` wins.
- **Changing `pl_last` mid-run:** the new value is used at the next entry advance. If `entry_idx` is already greater than `pl_last`, the next advance wraps to 0.

## Timing
- **Reset values:** all outputs are 0, the state is IDLE, and every playlist entry is {anim 0, loops 0}.
- `frame_start` rises 1 cycle after `play` is sampled.
- The minimum frame period is FRAME_TIME+2 cycles: START (1) + RUN (FRAME_TIME) + ADVANCE (1).
- `anim_id`, `frame_offset` and `entry_idx` change only on the edge that leaves ADVANCE. They are stable throughout START and RUN.
- `pl_wrap` is asserted in the same cycle as the START that follows the wrap.
- `frame_done` is sampled only in RUN; a pulse in any other state is ignored.
- Asserting `rst_n` low mid-frame clears all state immediately (asynchronously).

## Configuration
- `LED_CUBE_PAUSE_EN` defined:
  - While `pause`=1 in RUN, the timer holds. `frame_done` is still latched into `done_seen`, but the transition to ADVANCE is blocked.
  - `pause`=1 in START, ADVANCE or IDLE has no effect.
  - `stop` overrides `pause`.
- `LED_CUBE_PAUSE_EN` undefined: the `pause` port exists but is ignored, with no logic behind it.

## Test plan
The bench uses FRAME_TIME=16 and FRAMES=4. The driver model returns `frame_done` 10 cycles after each `frame_start` unless a scenario says otherwise.
- **Basic walk:** entries 0={anim 2, loops 0} and 1={anim 5, loops 1}, `pl_last`=1, then `play`. Required: `anim_id` sequence is 2×4 frames, then 5×8 frames. `pl_wrap` pulses once, then the sequence repeats. Each frame period is exactly 18 cycles.
- **Slow driver:** `frame_done` arrives 30 cycles after `frame_start`. Required: the frame period stretches to 32 cycles, and there is exactly one `frame_start` per `frame_done`.
- **Stop races:** `stop` together with `play` in IDLE → the block stays in IDLE with `busy`=0. `stop` at frame 3 of a run → IDLE next cycle, with all outputs 0.
- **Live write:** while entry 0 is playing anim 2, write entry 0 to anim 4. Required: the current pass keeps anim 2; after the wrap, `anim_id` is 4.
- **Reset mid-RUN:** drive `rst_n` low at timer=7. Required: outputs go to 0 without waiting for a clock edge, and the playlist returns to {0,0}.
- **Pause (only with `LED_CUBE_PAUSE_EN`):** hold `pause` high for 20 cycles in RUN. Required: the frame period becomes 38 cycles, and `frame_offset` does not advance during the pause.
